// File: rtl/pdm_mic_decimator.sv
// PDM microphone receiver: generates the mic bit clock, captures the 1-bit stream on the
// selected edge and decimates it to 16-bit signed PCM through a 3rd-order CIC filter.
`timescale 1ns/1ps
module pdm_mic_decimator #(
    parameter int CLK_DIV = 4,
    parameter int DECIM   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lr_sel,
    input  logic        pdm_data,
    output logic        pdm_clk,
    output logic [15:0] pcm_out,
    output logic        pcm_valid
);
    localparam int W  = 3 * $clog2(DECIM) + 2;
    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DECIM);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] RISE_CNT = CW'(CLK_DIV / 2 - 1);
    localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

    logic                clear;
    logic [CW-1:0]       div_q, div_d;
    logic                pdm_clk_q, pdm_clk_d;
    logic                cap_q, cap_d;
    logic                bit_q, bit_d;
    logic [DW-1:0]       dec_cnt_q, dec_cnt_d;
    logic                dec_q, dec_d;
    logic [2:0][W-1:0]   integ_q, integ_d;
    logic [2:0][W-1:0]   dly_q, dly_d;
    logic [W-1:0]        step;
    logic [W-1:0]        comb1, comb2, comb3;
    logic [15:0]         pcm_slice;
    logic [15:0]         pcm_q, pcm_d;
    logic                valid_q, valid_d;

    // en=0 behaves exactly like reset for every piece of state
    assign clear = !rst_n || !en;

    // Captured 1 -> +1, captured 0 -> -1, sign-extended to W bits
    assign step = bit_q ? W'(1) : {W{1'b1}};

    always_comb begin
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        pdm_clk_d = (div_d >= DIV_HALF);
        // Capture in the cycle whose edge moves pdm_clk across the selected transition
        cap_d     = lr_sel ? (div_q == DIV_LAST) : (div_q == RISE_CNT);
        bit_d     = cap_d ? pdm_data : bit_q;

        dec_cnt_d = dec_cnt_q;
        dec_d     = 1'b0;
        if (cap_q) begin
            dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
            dec_d     = (dec_cnt_q == DEC_LAST);
        end

        comb1   = integ_q[2] - dly_q[0];
        comb2   = comb1 - dly_q[1];
        comb3   = comb2 - dly_q[2];

        dly_d   = dly_q;
        pcm_d   = pcm_q;
        valid_d = 1'b0;
        if (dec_q) begin
            dly_d[0] = integ_q[2];
            dly_d[1] = comb1;
            dly_d[2] = comb2;
            pcm_d    = pcm_slice;
            valid_d  = 1'b1;
        end

        if (clear) begin
            div_d     = '0;
            pdm_clk_d = 1'b0;
            cap_d     = 1'b0;
            bit_d     = 1'b0;
            dec_cnt_d = '0;
            dec_d     = 1'b0;
            dly_d     = '0;
            pcm_d     = '0;
            valid_d   = 1'b0;
        end
    end

    // Integrator cascade: each stage accumulates the previous stage's registered value,
    // wrapping modulo 2^W; the comb section cancels the wrap exactly.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign integ_d[gi] = clear ? '0 :
                                     cap_q ? integ_q[gi] + step : integ_q[gi];
            end else begin : g_next
                assign integ_d[gi] = clear ? '0 :
                                     cap_q ? integ_q[gi] + integ_q[gi-1] : integ_q[gi];
            end
        end
    endgenerate

    generate
        if (W >= 16) begin : g_pcm_shr
            assign pcm_slice = comb3[W-1 -: 16];
        end else begin : g_pcm_shl
            assign pcm_slice = {comb3, {(16 - W){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        div_q     <= div_d;
        pdm_clk_q <= pdm_clk_d;
        cap_q     <= cap_d;
        bit_q     <= bit_d;
        dec_cnt_q <= dec_cnt_d;
        dec_q     <= dec_d;
        integ_q   <= integ_d;
        dly_q     <= dly_d;
        pcm_q     <= pcm_d;
        valid_q   <= valid_d;
    end

    assign pdm_clk   = pdm_clk_q;
    assign pcm_out   = pcm_q;
    assign pcm_valid = valid_q;

endmodule

// File: doc/pdm_mic_decimator.md
# pdm_mic_decimator

Receive-side counterpart of the PDM audio output: drives the bit clock of an external PDM MEMS microphone, captures its 1-bit stream and converts it to 16-bit signed PCM. It uses a 3rd-order CIC decimation filter. It sits on the audio PMOD input pins beside the PDM transmitter and hands PCM samples, with a one-cycle valid strobe, to downstream logic such as a loopback path to the PDM output, a level meter or a visualiser.

## Interface
- CLK_DIV, 4: clk cycles per pdm_clk period; even, ≥2.
- DECIM, 64: decimation ratio R; power of two, 8..256.
- W, 3*log2(DECIM)+2: internal integrator/comb width (derived; 20 at defaults).
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  1 = run; 0 = hold pdm_clk low and clear all datapath state.
- lr_sel  in  1  capture edge: 0 = pdm_clk rising, 1 = pdm_clk falling.
- pdm_data  in  1  microphone data bit.
- pdm_clk  out  1  microphone bit clock, 50 % duty.
- pcm_out  out  16  signed PCM sample, held between strobes.
- pcm_valid  out  1  one-cycle strobe: new pcm_out.

## Operation
- Divider: a counter of 0..CLK_DIV-1 drives pdm_clk from a register. pdm_clk is low for counts 0..CLK_DIV/2-1 and high otherwise.
- Capture: pdm_data is registered in the clk cycle in which the selected pdm_clk edge occurs, which samples the value present at the end of the preceding phase.
  - lr_sel=0: captures at low→high.
  - lr_sel=1: captures at high→low.
- Mapping: captured 1 → +1, captured 0 → −1. Both are sign-extended to W bits.
- Integrators: three cascaded W-bit accumulators. They update once per captured bit and wrap modulo 2^W. Two's-complement wrap is required and no saturation is allowed.
- Decimation: a counter of 0..DECIM-1 advances per captured bit. When it wraps, the third integrator's value enters the comb section.
- Combs: three cascaded W-bit differencers, each with a delay of 1 decimated sample. They operate modulo 2^W.
- Output: pcm_out = comb3[W-1 -: 16], i.e. an arithmetic shift right by W-16.
  - Full-scale steady +1 gives +DECIM^3 >> (W-16) = 0x4000 at defaults.
  - Full-scale steady −1 gives 0xC000.
- Settling: the first 3 strobes after reset or after en rises may be transient. From the 4th strobe onward, output equals the steady-state CIC response.
- en=0 has the same effect as reset: divider, decimation counter, integrators, comb delays and pcm_out are cleared, and pcm_valid is 0. The value of lr_sel during this time is irrelevant.
- lr_sel changes take effect at the next edge. They must not corrupt the divider.

## Timing
- Reset values: pdm_clk=0, pcm_out=0x0000, pcm_valid=0, all counters and accumulators 0.
- First pdm_clk rise occurs CLK_DIV/2 clks after rst_n (or en) goes high.
- Integrators update 1 clk after a capture.
- pcm_valid pulses exactly 2 clks after the capture of every DECIM-th bit. pcm_out changes in that same cycle.
- Strobe spacing is exactly DECIM*CLK_DIV clks (256 at defaults). pcm_valid is never high on consecutive cycles.
- Reset or en=0 mid-sample discards the partial sample and produces no strobe.
- Counting restarts at 0 when the block leaves reset or en=0.

## Test plan
- Defaults, pdm_data=1 constant, 20 strobes -> strobes spaced 256 clks; pdm_clk period 4, 2 high/2 low; pcm_out=0x4000 from the 4th strobe onward.
- pdm_data=0 constant -> pcm_out=0xC000 from the 4th strobe onward.
- pdm_data alternating 1,0 per captured bit -> pcm_out=0x0000 from the 4th strobe onward.
- pdm_data=1 during pdm_clk high phase, 0 during low phase:
  - lr_sel=1 -> pcm_out=0x4000.
  - lr_sel=0 -> pcm_out=0xC000.
- en dropped for 10 clks midway through a sample -> pdm_clk low the next cycle; pcm_out=0; no strobe. After en rises, the first strobe is 2+DECIM*CLK_DIV-CLK_DIV/2 clks later, and the 4th strobe reads 0x4000 again with pdm_data=1.
- Run 200 000 clks with pdm_data=1 so the integrators wrap repeatedly -> every strobe after the 3rd reads exactly 0x4000. Repeat with DECIM=8, CLK_DIV=2 (W=11): expect 512>>… = 0x4000 and strobe spacing 16 clks.
